// File: rtl/fp_writeback_if.sv
// FP writeback bus: ALU result and load-return handshakes, issue marking, scoreboard and RF write port.
interface fp_writeback_if #(
   parameter int DATA_W = 16
);
   logic              alu_valid;
   logic              alu_ready;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic              ld_ready;
   logic [4:0]        ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              issue_set;
   logic [4:0]        issue_rd;
   logic [31:0]       busy;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_set, issue_rd,
      output alu_ready, ld_ready, busy, rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_set, issue_rd,
      input  alu_ready, ld_ready, busy, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/fp_writeback.sv
// FP writeback arbiter: load FIFO vs ALU, one registered RF write per cycle (latency 1) plus busy scoreboard.
// Backpressure: ld_ready/alu_ready both drop only while the load FIFO is full; a full FIFO always drains first.
module fp_writeback #(
   parameter int DATA_W   = 16,
   parameter int LD_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   fp_writeback_if.slave wb
);
   localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LD_DEPTH);

   typedef struct packed {
      logic [4:0]        rd;
      logic [DATA_W-1:0] dat;
   } ld_ent_t;

   ld_ent_t           fifo_mem [LD_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_nxt;
   logic              full, empty, push, pop;
   ld_ent_t           head;

   logic              sel_we;
   logic [4:0]        sel_rd;
   logic [DATA_W-1:0] sel_dat;

   logic              rf_we_q;
   logic [4:0]        rf_waddr_q;
   logic [DATA_W-1:0] rf_wdata_q;
   logic [31:0]       busy_q, busy_nxt;

   // Readies come only from the registered count so neither depends on same-cycle valids.
   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);
   assign push  = wb.ld_valid && !full;
   assign head  = fifo_mem[rd_ptr];

   assign wb.ld_ready  = !full;
   assign wb.alu_ready = !full;
   assign wb.busy      = busy_q;
   assign wb.rf_we     = rf_we_q;
   assign wb.rf_waddr  = rf_waddr_q;
   assign wb.rf_wdata  = rf_wdata_q;

   // A full FIFO beats the ALU; otherwise the ALU wins and loads fill idle slots.
   // Selection looks at pre-push state, so a load never bypasses the FIFO.
   always_comb begin
      sel_we  = 1'b0;
      sel_rd  = '0;
      sel_dat = '0;
      pop     = 1'b0;
      if (full) begin
         pop     = 1'b1;
         sel_we  = 1'b1;
         sel_rd  = head.rd;
         sel_dat = head.dat;
      end else if (wb.alu_valid) begin
         sel_we  = 1'b1;
         sel_rd  = wb.alu_rd;
         sel_dat = wb.alu_data;
      end else if (!empty) begin
         pop     = 1'b1;
         sel_we  = 1'b1;
         sel_rd  = head.rd;
         sel_dat = head.dat;
      end
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_ONE;
      end else if (pop && !push) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // Set is applied after clear so a same-cycle issue keeps the register pending.
   always_comb begin
      busy_nxt = busy_q;
      if (rf_we_q) begin
         busy_nxt[rf_waddr_q] = 1'b0;
      end
      if (wb.issue_set) begin
         busy_nxt[wb.issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{rd: wb.ld_rd, dat: wb.ld_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count      <= count_nxt;
         rf_we_q    <= sel_we;
         rf_waddr_q <= sel_rd;
         rf_wdata_q <= sel_dat;
         busy_q     <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_fp_writeback.sv
// Bench for fp_writeback: vector table, directed multi-cycle sequences, then random traffic against a queue model.
module tb_fp_writeback;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   fp_writeback_if #(.DATA_W(DW)) bus ();

   fp_writeback #(.DATA_W(DW), .LD_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  rd;
      logic [15:0] d;
      logic        ewe;
      logic [4:0]  ewa;
      logic [15:0] ewd;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [15:0] d;
   } ent_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = '0;
      bus.ld_data   = '0;
      bus.issue_set = 1'b0;
      bus.issue_rd  = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic chk_wr(input string nm, input logic [4:0] wa, input logic [15:0] wd);
      chk({nm, "_we"}, 32'(bus.rf_we), 32'd1);
      chk({nm, "_waddr"}, 32'(bus.rf_waddr), 32'(wa));
      chk({nm, "_wdata"}, 32'(bus.rf_wdata), 32'(wd));
   endtask

   // Reference model state for the random phase
   ent_t        mq[$];
   logic [31:0] mbusy;
   logic        mwe;
   logic [4:0]  mwa;
   logic [15:0] mwd;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle();
      rst_n = 1'b0;
      step();
      step();
      chk("rst_busy", bus.busy, 32'd0);
      chk("rst_we", 32'(bus.rf_we), 32'd0);
      chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_wdata", 32'(bus.rf_wdata), 32'd0);
      rst_n = 1'b1;
      chk("rel_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
      step();
      chk("rel_we", 32'(bus.rf_we), 32'd0);

      // Single-cycle ALU writes with an empty FIFO
      tbl[0] = '{1'b1, 5'd5,  16'h3C00, 1'b1, 5'd5,  16'h3C00};
      tbl[1] = '{1'b0, 5'd5,  16'h3C00, 1'b0, 5'd0,  16'h0000};
      tbl[2] = '{1'b1, 5'd0,  16'hFFFF, 1'b1, 5'd0,  16'hFFFF};
      tbl[3] = '{1'b1, 5'd31, 16'h0001, 1'b1, 5'd31, 16'h0001};
      tbl[4] = '{1'b1, 5'd31, 16'h8000, 1'b1, 5'd31, 16'h8000};
      tbl[5] = '{1'b0, 5'd12, 16'h1111, 1'b0, 5'd0,  16'h0000};
      for (int i = 0; i < 6; i++) begin
         bus.alu_valid = tbl[i].av;
         bus.alu_rd    = tbl[i].rd;
         bus.alu_data  = tbl[i].d;
         step();
         chk($sformatf("tbl%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].ewe));
         if (tbl[i].ewe) begin
            chk($sformatf("tbl%0d_waddr", i), 32'(bus.rf_waddr), 32'(tbl[i].ewa));
            chk($sformatf("tbl%0d_wdata", i), 32'(bus.rf_wdata), 32'(tbl[i].ewd));
         end
      end
      idle();

      // Busy set by issue, cleared on the edge after the write
      bus.issue_set = 1'b1;
      bus.issue_rd  = 5'd7;
      step();
      idle();
      chk("busy7_set", 32'(bus.busy[7]), 32'd1);
      step();
      chk("busy7_hold", 32'(bus.busy[7]), 32'd1);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd7;
      bus.alu_data  = 16'h1234;
      step();
      idle();
      chk_wr("busy7_wr", 5'd7, 16'h1234);
      chk("busy7_during_we", 32'(bus.busy[7]), 32'd1);
      step();
      chk("busy7_clr", 32'(bus.busy[7]), 32'd0);

      // Set wins over a same-cycle clear
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd9;
      bus.alu_data  = 16'h0909;
      step();
      idle();
      chk_wr("busy9_wr", 5'd9, 16'h0909);
      bus.issue_set = 1'b1;
      bus.issue_rd  = 5'd9;
      step();
      idle();
      chk("busy9_setwins", 32'(bus.busy[9]), 32'd1);
      step();
      chk("busy9_stays", 32'(bus.busy[9]), 32'd1);

      // Four loads against a busy ALU: FIFO fills, drains in order, ALU resumes
      for (int i = 0; i < 4; i++) begin
         bus.ld_valid  = 1'b1;
         bus.ld_rd     = 5'(i + 1);
         bus.ld_data   = 16'hA000 + 16'(i);
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'(20 + i);
         bus.alu_data  = 16'hB000 + 16'(i);
         chk($sformatf("fill%0d_ld_ready", i), 32'(bus.ld_ready), 32'd1);
         step();
         chk_wr($sformatf("fill%0d_alu", i), 5'(20 + i), 16'hB000 + 16'(i));
      end
      bus.ld_valid = 1'b0;
      bus.alu_rd   = 5'd24;
      bus.alu_data = 16'hB004;
      chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("full_alu_ready", 32'(bus.alu_ready), 32'd0);
      step();
      chk_wr("drain_ld1", 5'd1, 16'hA000);
      chk("after_pop_alu_ready", 32'(bus.alu_ready), 32'd1);
      step();
      chk_wr("alu_resume", 5'd24, 16'hB004);
      bus.alu_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         step();
         chk_wr($sformatf("drain_ld%0d", i + 1), 5'(i + 1), 16'hA000 + 16'(i));
      end
      step();
      chk("drained_we", 32'(bus.rf_we), 32'd0);

      // Reset with three loads queued: nothing stale may be written afterwards
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid  = 1'b1;
         bus.ld_rd     = 5'(11 + i);
         bus.ld_data   = 16'hD000 + 16'(i);
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'd30;
         bus.alu_data  = 16'h0E0E;
         bus.issue_set = 1'b1;
         bus.issue_rd  = 5'(3 + i);
         step();
      end
      do_reset();
      chk("mid_rst_busy", bus.busy, 32'd0);
      chk("mid_rst_we", 32'(bus.rf_we), 32'd0);
      chk("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("no_stale%0d_we", i), 32'(bus.rf_we), 32'd0);
      end

      // Push and pop together at count 2, across two pointer wraps
      for (int i = 0; i < 2; i++) begin
         bus.ld_valid  = 1'b1;
         bus.ld_rd     = 5'(1 + i);
         bus.ld_data   = 16'hC000 + 16'(i);
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'd17;
         bus.alu_data  = 16'h7777;
         step();
      end
      bus.alu_valid = 1'b0;
      for (int i = 2; i < 8; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_rd    = 5'(1 + i);
         bus.ld_data  = 16'hC000 + 16'(i);
         step();
         chk_wr($sformatf("pp%0d", i - 2), 5'(i - 1), 16'hC000 + 16'(i - 2));
         chk($sformatf("pp%0d_ld_ready", i - 2), 32'(bus.ld_ready), 32'd1);
      end
      bus.ld_valid = 1'b0;
      for (int i = 6; i < 8; i++) begin
         step();
         chk_wr($sformatf("pp_tail%0d", i), 5'(1 + i), 16'hC000 + 16'(i));
      end
      step();
      chk("pp_empty_we", 32'(bus.rf_we), 32'd0);

      // Random traffic against the queue model
      do_reset();
      mq.delete();
      mbusy = '0;
      mwe   = 1'b0;
      mwa   = '0;
      mwd   = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [31:0] nbusy;
         logic        mfull;
         ent_t        e;
         bus.alu_valid = ($urandom_range(3, 0) != 0);
         bus.alu_rd    = 5'($urandom);
         bus.alu_data  = 16'($urandom);
         bus.ld_valid  = ($urandom_range(3, 0) != 0);
         bus.ld_rd     = 5'($urandom);
         bus.ld_data   = 16'($urandom);
         bus.issue_set = ($urandom_range(1, 0) != 0);
         bus.issue_rd  = 5'($urandom);

         chk("rnd_ld_ready", 32'(bus.ld_ready), 32'(mq.size() < DEPTH));
         chk("rnd_alu_ready", 32'(bus.alu_ready), 32'(mq.size() < DEPTH));
         chk("rnd_we", 32'(bus.rf_we), 32'(mwe));
         if (mwe) begin
            chk("rnd_waddr", 32'(bus.rf_waddr), 32'(mwa));
            chk("rnd_wdata", 32'(bus.rf_wdata), 32'(mwd));
         end
         chk("rnd_busy", bus.busy, mbusy);

         nbusy = mbusy;
         if (mwe) nbusy[mwa] = 1'b0;
         if (bus.issue_set) nbusy[bus.issue_rd] = 1'b1;
         mbusy = nbusy;

         mfull = (mq.size() == DEPTH);
         if (mfull || (!bus.alu_valid && mq.size() > 0)) begin
            e   = mq.pop_front();
            mwe = 1'b1;
            mwa = e.rd;
            mwd = e.d;
         end else if (bus.alu_valid) begin
            mwe = 1'b1;
            mwa = bus.alu_rd;
            mwd = bus.alu_data;
         end else begin
            mwe = 1'b0;
         end
         if (bus.ld_valid && !mfull) begin
            mq.push_back('{bus.ld_rd, bus.ld_data});
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fp_writeback.md
FP_WRITEBACK -- requirements
Module: fp_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FP register data width.
REQ-002 SHALL have parameter LD_DEPTH, default 4, load-return FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alu_valid  input  1  FP ALU result valid.
REQ-006 SHALL have port alu_ready  output  1  FP ALU result accepted when alu_valid&&alu_ready.
REQ-007 SHALL have port alu_rd  input  5  FP ALU destination register.
REQ-008 SHALL have port alu_data  input  DATA_W  FP ALU result.
REQ-009 SHALL have port ld_valid  input  1  load-return valid.
REQ-010 SHALL have port ld_ready  output  1  load return accepted when ld_valid&&ld_ready.
REQ-011 SHALL have port ld_rd  input  5  load destination register.
REQ-012 SHALL have port ld_data  input  DATA_W  load data.
REQ-013 SHALL have port issue_set  input  1  issue stage marks issue_rd pending.
REQ-014 SHALL have port issue_rd  input  5  register being marked pending.
REQ-015 SHALL have port busy  output  32  scoreboard; bit r=1 means write to FP reg r outstanding.
REQ-016 SHALL have port rf_we  output  1  write enable to FP register file.
REQ-017 SHALL have port rf_waddr  output  5  write address to FP register file.
REQ-018 SHALL have port rf_wdata  output  DATA_W  write data to FP register file.

Function
REQ-019 SHALL buffer accepted load returns in an in-order FIFO of LD_DEPTH entries {rd, data}.
REQ-020 SHALL drive ld_ready = (fifo count < LD_DEPTH), combinational from registered count only.
REQ-021 SHALL select one write per cycle: if FIFO full, FIFO head; else if alu_valid, ALU; else if FIFO non-empty, FIFO head; else none.
REQ-022 SHALL drive alu_ready = !(fifo count == LD_DEPTH); alu_ready SHALL NOT depend on ld_valid.
REQ-023 SHALL pop the FIFO head in the cycle it is selected; push and pop in same cycle SHALL leave count unchanged.
REQ-024 SHALL register the selected write: rf_we/rf_waddr/rf_wdata valid exactly 1 cycle after selection (latency 1).
REQ-025 SHALL hold rf_we=0 in any cycle following a cycle with no selection; rf_waddr/rf_wdata then don't-care.
REQ-026 SHALL, with FIFO empty and ld_valid accepted, permit that entry to be selected no earlier than the next cycle (no bypass).
REQ-027 SHALL set busy[issue_rd] on the edge where issue_set=1.
REQ-028 SHALL clear busy[rf_waddr] on the edge ending a cycle with rf_we=1.
REQ-029 SHALL, on simultaneous set and clear of the same bit, leave it set (set wins).
REQ-030 SHALL treat all 32 registers identically (no hardwired-zero register).
REQ-031 SHALL wrap FIFO read/write pointers modulo LD_DEPTH; count range 0..LD_DEPTH.
REQ-032 SHALL NOT check busy when accepting results; ordering of writes to same rd is caller's responsibility.

Reset
REQ-033 SHALL, while rst_n=0 at an edge, set busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, FIFO count and pointers=0.
REQ-034 SHALL discard any FIFO contents and in-flight write on reset mid-operation; no rf_we the cycle after reset release.
REQ-035 SHALL drive ld_ready=1 and alu_ready=1 in the first cycle after reset release.

Verification
REQ-036 SHALL cover: alu_valid=1, alu_rd=5, alu_data=16'h3C00 one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=16'h3C00; then rf_we=0.
REQ-037 SHALL cover: ld_valid with rd=1..4 on 4 back-to-back cycles while alu_valid=1 continuously -> ld_ready falls after 4th accept, alu_ready=0 while full, loads written in order 1,2,3,4, ALU writes resume.
REQ-038 SHALL cover: issue_set rd=7, later ALU result rd=7 -> busy[7]=1 until edge after rf_we for 7, then 0.
REQ-039 SHALL cover: issue_set rd=9 in same cycle rf_we=1, rf_waddr=9 -> busy[9] remains 1.
REQ-040 SHALL cover: FIFO holding 3 entries, rst_n=0 one cycle -> busy=0, rf_we=0, ld_ready=1, no stale load ever written.
REQ-041 SHALL cover: ld push and pop in same cycle with count=2 -> count stays 2, data order preserved across pointer wrap.
